disp_reg_access_initiator: RTL and testbench

//  Initiator side of the dispatcher register-access interface: converts a single

---
 rtl/disp_reg_access_initiator.sv | 136 +++++++++++++
 tb/tb_disp_reg_access_initiator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_reg_access_initiator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | disp_reg_access_initiator: command stream -> Write/Read valid-ack register   |
// | transactions with per-transaction timeout.       Rev 1.0 - initial release   |
// +-----------------------------------------------------------------------------+
module disp_reg_access_initiator #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic        iCmdOpcode,
  input  logic [31:0] iCmdAddress,
  input  logic [31:0] iCmdData,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic [31:0] oRespData,
  output logic        oRespError,
  output logic [31:0] oWriteAddress,
  output logic [31:0] oWriteData,
  output logic        oWriteValid,
  input  logic        iWriteAck,
  output logic [31:0] oReadAddress,
  input  logic [31:0] iReadData,
  output logic        oReadValid,
  input  logic        iReadAck
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] timer_q, timer_d;
  logic        wvalid_q, wvalid_d;
  logic        rvalid_q, rvalid_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  logic        ack;
  logic        expire;

  assign oCmdReady = (state_q == IDLE) & ~iReset;

  // Only the ack of the direction in flight counts; the other one is ignored.
  assign ack    = ((state_q == WRITE) & iWriteAck) | ((state_q == READ) & iReadAck);
  assign expire = (timer_q == TIMER_LAST);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    timer_d      = timer_q;
    wvalid_d     = wvalid_q;
    rvalid_d     = rvalid_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (iCmdValid & oCmdReady) begin
          state_d  = iCmdOpcode ? WRITE : READ;
          addr_d   = iCmdAddress;
          data_d   = iCmdData;
          timer_d  = 16'd0;
          wvalid_d = iCmdOpcode;
          rvalid_d = ~iCmdOpcode;
        end
      end
      WRITE, READ: begin
        // An ack arriving on the expiry cycle still counts as success.
        if (ack | expire) begin
          state_d      = RESP;
          wvalid_d     = 1'b0;
          rvalid_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_error_d = ~ack;
          resp_data_d  = (ack & (state_q == READ)) ? iReadData : 32'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP: begin
        if (iRespReady) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      timer_q      <= 16'd0;
      wvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      wvalid_q     <= wvalid_d;
      rvalid_q     <= rvalid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign oWriteAddress = addr_q;
  assign oReadAddress  = addr_q;
  assign oWriteData    = data_q;
  assign oWriteValid   = wvalid_q;
  assign oReadValid    = rvalid_q;
  assign oRespValid    = resp_valid_q;
  assign oRespData     = resp_data_q;
  assign oRespError    = resp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_reg_access_initiator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_disp_reg_access_initiator: scoreboard bench for disp_reg_access_initiator |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
module tb_disp_reg_access_initiator;

  localparam int TO = 8;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iCmdValid;
  logic        oCmdReady;
  logic        iCmdOpcode;
  logic [31:0] iCmdAddress;
  logic [31:0] iCmdData;
  logic        oRespValid;
  logic        iRespReady;
  logic [31:0] oRespData;
  logic        oRespError;
  logic [31:0] oWriteAddress;
  logic [31:0] oWriteData;
  logic        oWriteValid;
  logic        iWriteAck;
  logic [31:0] oReadAddress;
  logic [31:0] iReadData;
  logic        oReadValid;
  logic        iReadAck;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 iClock = ~iClock;

  disp_reg_access_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iCmdValid     (iCmdValid),
    .oCmdReady     (oCmdReady),
    .iCmdOpcode    (iCmdOpcode),
    .iCmdAddress   (iCmdAddress),
    .iCmdData      (iCmdData),
    .oRespValid    (oRespValid),
    .iRespReady    (iRespReady),
    .oRespData     (oRespData),
    .oRespError    (oRespError),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oWriteValid   (oWriteValid),
    .iWriteAck     (iWriteAck),
    .oReadAddress  (oReadAddress),
    .iReadData     (iReadData),
    .oReadValid    (oReadValid),
    .iReadAck      (iReadAck)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  // One command: ack on valid cycle ack_at (0 = never), optional backpressure
  // on the response, optional reset on valid cycle rst_at.
  task automatic run_cmd(input logic op, input logic [31:0] addr, input logic [31:0] data,
                         input int ack_at, input logic [31:0] rdata, input int resp_wait,
                         input logic hold, input int rst_at);
    int    n;
    int    cnt;
    resp_t e;
    resp_t p;
    iCmdValid   = 1'b1;
    iCmdOpcode  = op;
    iCmdAddress = addr;
    iCmdData    = data;
    n = 0;
    while (!oCmdReady && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready", 32'(oCmdReady), 32'd1);
    tick();
    e.err  = !(ack_at >= 1 && ack_at <= TO);
    e.data = (!e.err && !op) ? rdata : 32'd0;
    sb.push_back(e);
    iCmdValid   = 1'b0;
    iCmdAddress = $urandom;
    iCmdData    = $urandom;
    cnt = 0;
    while ((oWriteValid || oReadValid) && cnt < 40) begin
      cnt++;
      check("dir_valid", op ? {30'd0, oWriteValid, oReadValid} : {30'd0, oReadValid, oWriteValid}, 32'd2);
      check("addr", op ? oWriteAddress : oReadAddress, addr);
      if (op) check("wdata", oWriteData, data);
      if (rst_at == cnt) begin
        iReset = 1'b1;
        tick();
        check("rst_wvalid", 32'(oWriteValid), 32'd0);
        check("rst_rvalid", 32'(oReadValid), 32'd0);
        check("rst_respvalid", 32'(oRespValid), 32'd0);
        check("rst_cmdready", 32'(oCmdReady), 32'd0);
        check("rst_raddr", oReadAddress, 32'd0);
        iReset = 1'b0;
        #1;
        check("rst_release_ready", 32'(oCmdReady), 32'd1);
        sb.delete();
        for (int i = 0; i < 10; i++) begin
          tick();
          check("rst_no_resp", 32'(oRespValid), 32'd0);
        end
        return;
      end
      iWriteAck = op ? (cnt == ack_at) : 1'b1;
      iReadAck  = op ? 1'b1 : (cnt == ack_at);
      iReadData = (!op && cnt == ack_at) ? rdata : $urandom;
      tick();
      iWriteAck = 1'b0;
      iReadAck  = 1'b0;
    end
    check("valid_cycles", 32'(cnt), e.err ? 32'(TO) : 32'(ack_at));
    check("resp_valid", 32'(oRespValid), 32'd1);
    for (int i = 0; i < resp_wait; i++) begin
      iCmdValid = hold;
      iWriteAck = 1'b1;
      iReadAck  = 1'b1;
      iReadData = $urandom;
      check("ready_in_resp", 32'(oCmdReady), 32'd0);
      check("hold_data", oRespData, e.data);
      check("hold_err", 32'(oRespError), 32'(e.err));
      tick();
    end
    iWriteAck  = 1'b0;
    iReadAck   = 1'b0;
    iRespReady = 1'b1;
    check("consume_valid", 32'(oRespValid), 32'd1);
    check("consume_ready", 32'(oCmdReady), 32'd0);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      p = sb.pop_front();
      check("resp_data", oRespData, p.data);
      check("resp_err", 32'(oRespError), 32'(p.err));
    end
    tick();
    iRespReady = 1'b0;
    check("resp_drop", 32'(oRespValid), 32'd0);
    check("no_accept_consume", {30'd0, oWriteValid, oReadValid}, 32'd0);
  endtask

  initial begin
    iReset      = 1'b1;
    iCmdValid   = 1'b0;
    iCmdOpcode  = 1'b0;
    iCmdAddress = 32'd0;
    iCmdData    = 32'd0;
    iRespReady  = 1'b0;
    iWriteAck   = 1'b0;
    iReadAck    = 1'b0;
    iReadData   = 32'd0;
    repeat (3) tick();
    check("reset_cmdready", 32'(oCmdReady), 32'd0);
    check("reset_valids", {29'd0, oWriteValid, oReadValid, oRespValid}, 32'd0);
    check("reset_waddr", oWriteAddress, 32'd0);
    check("reset_wdata", oWriteData, 32'd0);
    check("reset_respdata", oRespData, 32'd0);
    check("reset_resperr", 32'(oRespError), 32'd0);
    iReset = 1'b0;
    #1;
    check("reset_release_ready", 32'(oCmdReady), 32'd1);

    run_cmd(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 3, 32'd0, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h0000_0010, 32'd0, 1, 32'h1234_5678, 0, 1'b0, 0);
    run_cmd(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'd0, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h0000_0030, 32'd0, 8, 32'hA5A5_A5A5, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h0000_0034, 32'd0, 9, 32'h5555_AAAA, 1, 1'b0, 0);
    run_cmd(1'b0, 32'h0000_0040, 32'd0, 2, 32'h0BAD_F00D, 5, 1'b1, 0);
    run_cmd(1'b1, 32'h0000_0044, 32'h1111_2222, 1, 32'd0, 2, 1'b0, 0);
    run_cmd(1'b0, 32'h0000_0050, 32'd0, 0, 32'd0, 0, 1'b0, 3);
    run_cmd(1'b1, 32'h0000_0060, 32'h7777_8888, 2, 32'd0, 0, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 10)),
              $urandom, int'($urandom_range(0, 3)), 1'b0, 0);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
